// File: rtl/mux_rr_sequencer_if.sv
// mux_rr_sequencer_if
//   Bundles the request/grant, mux select/data and downstream valid/ready
//   signals that pass between the round-robin sequencer and its neighbours.
//
//   req       requester array -> sequencer, one bit per mux input
//   gnt       sequencer -> requesters, one-hot capture pulse
//   sel       sequencer -> mux, registered select
//   mux_out   mux -> sequencer, combinational mux output
//   out_data  sequencer -> consumer, captured word
//   out_valid sequencer -> consumer
//   out_ready consumer -> sequencer
//
//   master: the sequencer side.  slave: the environment (requesters, mux,
//   consumer) side.
interface mux_rr_sequencer_if #(
  parameter int unsigned NUM_INP = 31,
  parameter int unsigned SEL_W   = 5
);
  logic [NUM_INP-1:0] req;
  logic [NUM_INP-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic [1:0]         mux_out;
  logic [1:0]         out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    input  req, mux_out, out_ready,
    output gnt, sel, out_data, out_valid
  );

  modport slave (
    output req, mux_out, out_ready,
    input  gnt, sel, out_data, out_valid
  );
endinterface

// File: rtl/mux_rr_sequencer.sv
// mux_rr_sequencer
//   Round-robin sequencer for a 31-input, 2-bit mux. Picks the next pending
//   requester after the last one served, drives the mux select, waits
//   SETTLE_CYCLES for the mux to settle, captures mux_out and offers the
//   captured word downstream on a valid/ready handshake. It is the only
//   driver of the mux select.
//
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   enable  permits a new arbitration from IDLE
//   bus     mux_rr_sequencer_if.master (req, gnt, sel, mux_out,
//           out_data, out_valid, out_ready)
//   busy    high whenever the sequencer is not in IDLE
module mux_rr_sequencer #(
  parameter int unsigned NUM_INP       = 31,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  mux_rr_sequencer_if.master  bus,
  output logic                busy
);

  localparam int unsigned SEL_W = 5;
  localparam logic [2:0]  CNT_INIT = 3'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_INP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    last_q, last_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [1:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic [NUM_INP-1:0]  gnt_q, gnt_d;

  // Round-robin pick: scan last+1, last+2, ... wrapping at NUM_INP so that
  // last itself is the final candidate.
  logic [SEL_W-1:0]    pick;
  logic                found;

  always_comb begin
    int unsigned       pos;
    logic [SEL_W-1:0]  pk;
    pick  = last_q;
    found = 1'b0;
    pos   = 0;
    pk    = '0;
    for (int unsigned k = 1; k <= NUM_INP; k++) begin
      pos = 32'(last_q) + k;
      if (pos >= NUM_INP) begin
        pos = pos - NUM_INP;
      end
      pk = SEL_W'(pos);
      if (!found && bus.req[pk]) begin
        found = 1'b1;
        pick  = pk;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  // sel_q doubles as the granted index while in SETTLE/HOLD, since it is
  // frozen from the arbitration edge until the next IDLE decision.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    gnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (enable && found) begin
          sel_d   = pick;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          data_d  = bus.mux_out;
          valid_d = 1'b1;
          gnt_d   = NUM_INP'(1) << sel_q;
          last_d  = sel_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mux_rr_sequencer.sv
module tb_mux_rr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: SETTLE_CYCLES = 1
  logic       rst_a, en_a, busy_a;
  logic [1:0] mux_in_a [31];
  mux_rr_sequencer_if ifa ();
  assign ifa.mux_out = (ifa.sel < 5'd31) ? mux_in_a[ifa.sel] : 2'b00;

  mux_rr_sequencer #(.NUM_INP(31), .SETTLE_CYCLES(1)) dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .enable (en_a),
    .bus    (ifa),
    .busy   (busy_a)
  );

  // instance B: SETTLE_CYCLES = 4
  logic       rst_b, en_b, busy_b;
  logic [1:0] mux_in_b [31];
  mux_rr_sequencer_if ifb ();
  assign ifb.mux_out = (ifb.sel < 5'd31) ? mux_in_b[ifb.sel] : 2'b00;

  mux_rr_sequencer #(.NUM_INP(31), .SETTLE_CYCLES(4)) dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .enable (en_b),
    .bus    (ifb),
    .busy   (busy_b)
  );

  int nvec  = 0;
  int nfail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0] idx;
    logic [1:0] data;
  } exp_t;

  exp_t sbq [$];
  int   ngnt = 0;
  int   cyc  = 0;
  int   gcyc [$];
  int   model_last = 30;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for instance A: every grant pulse must match the
  // oldest expected transaction.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_a && ifa.gnt != '0) begin
      ngnt++;
      gcyc.push_back(cyc);
      if (sbq.size() == 0) begin
        check_val("gnt_unexpected", 32'(ifa.gnt), 32'h0);
      end else begin
        e = sbq.pop_front();
        check_val("sb_gnt", 32'(ifa.gnt), 32'h1 << e.idx);
        check_val("sb_sel", 32'(ifa.sel), 32'(e.idx));
        check_val("sb_data", 32'(ifa.out_data), 32'(e.data));
        check_val("sb_valid", 32'(ifa.out_valid), 32'h1);
      end
    end
  end

  function automatic int rr_pick(input logic [30:0] r, input int last);
    for (int k = 1; k <= 31; k++) begin
      int p;
      p = (last + k) % 31;
      if (r[p]) return p;
    end
    return last;
  endfunction

  task automatic push_exp(input int idx);
    exp_t e;
    e.idx  = 5'(idx);
    e.data = mux_in_a[idx];
    sbq.push_back(e);
    model_last = idx;
  endtask

  task automatic wait_grants(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (ngnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(ngnt), 32'(target));
  endtask

  task automatic check_gaps(input int base, input string tag);
    for (int i = base + 1; i < gcyc.size(); i++) begin
      check_val(tag, 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int         base;
    logic [1:0] d7;
    logic [1:0] seq_b [4];

    rst_a = 1'b1; en_a = 1'b0; ifa.req = '0; ifa.out_ready = 1'b1;
    rst_b = 1'b1; en_b = 1'b0; ifb.req = '0; ifb.out_ready = 1'b1;
    for (int i = 0; i < 31; i++) begin
      mux_in_a[i] = 2'($urandom_range(0, 3));
      mux_in_b[i] = 2'b00;
    end
    mux_in_a[0] = 2'b10;

    repeat (3) @(negedge clk);
    check_val("rst_sel", 32'(ifa.sel), 32'h0);
    check_val("rst_data", 32'(ifa.out_data), 32'h0);
    check_val("rst_valid", 32'(ifa.out_valid), 32'h0);
    check_val("rst_gnt", 32'(ifa.gnt), 32'h0);
    check_val("rst_busy", 32'(busy_a), 32'h0);
    rst_a = 1'b0; en_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b1;

    // T1: single request on bit 0, first search starts at index 0
    @(negedge clk);
    push_exp(0);
    ifa.req = 31'h1;
    @(negedge clk);
    check_val("t1_sel", 32'(ifa.sel), 32'h0);
    check_val("t1_busy", 32'(busy_a), 32'h1);
    check_val("t1_valid_early", 32'(ifa.out_valid), 32'h0);
    @(negedge clk);
    check_val("t1_valid", 32'(ifa.out_valid), 32'h1);
    check_val("t1_data", 32'(ifa.out_data), 32'h2);
    check_val("t1_gnt", 32'(ifa.gnt), 32'h1);
    ifa.req = '0;
    @(negedge clk);
    check_val("t1_gnt_pulse", 32'(ifa.gnt), 32'h0);
    check_val("t1_valid_done", 32'(ifa.out_valid), 32'h0);
    check_val("t1_idle", 32'(busy_a), 32'h0);
    repeat (2) @(negedge clk);

    // T2: all requesters, full rotation plus wrap, one grant per 3 cycles
    base = gcyc.size();
    for (int i = 0; i < 33; i++) push_exp(rr_pick('1, model_last));
    ifa.req = '1;
    wait_grants(ngnt + 33, 33 * 3 + 10, "t2_grants");
    ifa.req = '0;
    check_gaps(base, "t2_gap");
    repeat (3) @(negedge clk);

    // T3: bits 5 and 20 alternate, then lone bit 5 re-granted back-to-back
    push_exp(20);
    ifa.req = 31'(1) << 20;
    wait_grants(ngnt + 1, 10, "t3_pre");
    ifa.req = '0;
    repeat (3) @(negedge clk);
    push_exp(5); push_exp(20); push_exp(5);
    ifa.req = (31'(1) << 5) | (31'(1) << 20);
    wait_grants(ngnt + 3, 15, "t3_alt");
    ifa.req = '0;
    repeat (3) @(negedge clk);
    base = gcyc.size();
    push_exp(5); push_exp(5);
    ifa.req = 31'(1) << 5;
    wait_grants(ngnt + 2, 10, "t3_single");
    ifa.req = '0;
    check_gaps(base, "t3_gap");
    repeat (3) @(negedge clk);

    // T4: consumer stalls 10 cycles while the mux input keeps changing
    ifa.out_ready = 1'b0;
    push_exp(7);
    d7 = mux_in_a[7];
    ifa.req = 31'(1) << 7;
    wait_grants(ngnt + 1, 10, "t4_grant");
    ifa.req = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mux_in_a[7] = mux_in_a[7] ^ 2'b11;
      check_val("t4_hold_data", 32'(ifa.out_data), 32'(d7));
      check_val("t4_hold_valid", 32'(ifa.out_valid), 32'h1);
      check_val("t4_hold_sel", 32'(ifa.sel), 32'd7);
      check_val("t4_hold_gnt", 32'(ifa.gnt), 32'h0);
    end
    ifa.out_ready = 1'b1;
    @(negedge clk);
    check_val("t4_accept_valid", 32'(ifa.out_valid), 32'h0);
    check_val("t4_accept_busy", 32'(busy_a), 32'h0);
    repeat (2) @(negedge clk);

    // T6b: enable low blocks arbitration but not an in-flight transaction
    en_a = 1'b0;
    ifa.req = 31'(1) << 9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("t6b_busy", 32'(busy_a), 32'h0);
      check_val("t6b_sel", 32'(ifa.sel), 32'd7);
    end
    push_exp(9);
    en_a = 1'b1;
    @(negedge clk);
    check_val("t6b_sel_go", 32'(ifa.sel), 32'd9);
    check_val("t6b_busy_go", 32'(busy_a), 32'h1);
    en_a = 1'b0;
    wait_grants(ngnt + 1, 10, "t6b_inflight");
    ifa.req = '0;
    repeat (2) @(negedge clk);
    check_val("t6b_back_idle", 32'(busy_a), 32'h0);
    en_a = 1'b1;

    // T6a: reset during SETTLE abandons the transaction
    ifa.req = 31'(1) << 14;
    @(negedge clk);
    check_val("t6a_sel", 32'(ifa.sel), 32'd14);
    check_val("t6a_busy", 32'(busy_a), 32'h1);
    rst_a = 1'b1;
    ifa.req = '0;
    @(negedge clk);
    check_val("t6a_rst_sel", 32'(ifa.sel), 32'h0);
    check_val("t6a_rst_valid", 32'(ifa.out_valid), 32'h0);
    check_val("t6a_rst_data", 32'(ifa.out_data), 32'h0);
    check_val("t6a_rst_gnt", 32'(ifa.gnt), 32'h0);
    check_val("t6a_rst_busy", 32'(busy_a), 32'h0);
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("t6a_no_gnt", 32'(ifa.gnt), 32'h0);
    end
    model_last = 30;
    push_exp(rr_pick('1, model_last));
    ifa.req = '1;
    wait_grants(ngnt + 1, 10, "t6a_restart");
    ifa.req = '0;
    repeat (3) @(negedge clk);

    // T5: SETTLE_CYCLES=4, only the last settle-cycle value is captured
    seq_b[0] = 2'b01; seq_b[1] = 2'b10; seq_b[2] = 2'b00; seq_b[3] = 2'b11;
    mux_in_b[12] = 2'b00;
    ifb.req = 31'(1) << 12;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      mux_in_b[12] = seq_b[j];
      check_val("t5_sel", 32'(ifb.sel), 32'd12);
      check_val("t5_valid_early", 32'(ifb.out_valid), 32'h0);
      ifb.req = '0;
    end
    @(negedge clk);
    mux_in_b[12] = 2'b01;
    check_val("t5_valid", 32'(ifb.out_valid), 32'h1);
    check_val("t5_data", 32'(ifb.out_data), 32'h3);
    check_val("t5_gnt", 32'(ifb.gnt), 32'h1 << 12);
    @(negedge clk);
    check_val("t5_done", 32'(ifb.out_valid), 32'h0);
    check_val("t5_gnt_pulse", 32'(ifb.gnt), 32'h0);
    check_val("t5_idle", 32'(busy_b), 32'h0);

    check_val("sb_empty", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mux_rr_sequencer.md
Name: mux_rr_sequencer

Overview:
Round-robin sequencer for the 31-input, 2-bit selector mux. It arbitrates among 31 requesters and drives the mux `sel` lines. After a programmable settle time it captures the mux output into a registered result, and presents that result downstream on a valid/ready handshake. The block sits between the requester array and the consumer, and is the only agent allowed to drive the mux select.

Parameters:
- NUM_INP, 31, number of requesters and mux inputs; fixed at 31; `sel` width is 5.
- SETTLE_CYCLES, 1, cycles `sel` is held stable before `mux_out` is sampled; legal range 1..7.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, permits new arbitration when high.
- req, input, 31, `req[i]` high means requester i wants its mux input forwarded.
- gnt, output, 31, one-hot, one-cycle pulse marking which requester's data was captured.
- sel, output, 5, registered select driven to the mux.
- mux_out, input, 2, combinational output of the mux.
- out_data, output, 2, captured data word.
- out_valid, output, 1, `out_data` is valid.
- out_ready, input, 1, consumer accepts `out_data`.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (rst high at a rising edge):
  - state=IDLE, sel=0, out_data=0, out_valid=0, gnt=0, busy=0.
  - last_idx=30, so the first search starts at index 0.
  - Settle counter cleared.
- Reset mid-operation abandons the transaction:
  - outputs show reset values on the cycle after the reset edge.
  - no gnt pulse is issued for the abandoned transaction.
- IDLE:
  - If enable=1 and req!=0, pick idx as the first set bit of req, searching last_idx+1, last_idx+2, … with wrap 30→0. last_idx itself is searched last.
  - Then: sel<=idx, counter<=SETTLE_CYCLES-1, go to SETTLE.
  - Otherwise stay in IDLE; sel keeps its last value.
- SETTLE:
  - sel is held constant.
  - If counter!=0, decrement.
  - If counter==0: out_data<=mux_out, out_valid<=1, gnt<=one-hot(idx), last_idx<=idx, go to HOLD.
- HOLD:
  - gnt returns to 0 after exactly one cycle.
  - out_data and out_valid are held stable while out_ready=0.
  - On a cycle with out_valid=1 and out_ready=1: out_valid<=0, go to IDLE.
- Timing:
  - req sampled in IDLE at edge N.
  - sel is valid after edge N.
  - out_valid and gnt are high after edge N+SETTLE_CYCLES.
  - Minimum transaction is SETTLE_CYCLES+2 cycles (1 arbitrate + SETTLE_CYCLES + 1 handshake).
- Request sampling:
  - req is sampled only in IDLE.
  - Deasserting req[idx] after the decision does not abort the transaction; the data is still captured and granted.
- enable:
  - enable=0 blocks only the IDLE→SETTLE transition; an in-flight transaction completes normally.
- Range: sel never takes value 31.
- Fairness:
  - With all 31 requests held high, grants cycle 0,1,…,30,0,…
  - No requester waits more than 30 transactions.
- Single requester:
  - The same idx is re-granted back-to-back with no idle gap beyond the IDLE cycle.
- Outputs are registered; no combinational path from req or out_ready to any output.

Test Plan:
1. Reset then req=31'h1 (bit 0), mux_out=2'b10, SETTLE_CYCLES=1 → sel=0 one cycle after arbitration; out_valid=1, out_data=2'b10, gnt=31'h1 one cycle later.
2. All req bits high, out_ready=1 permanently → gnt bit sequence 0,1,2,…,30,0; sel never equals 31; one grant every 3 cycles.
3. req bits 5 and 20 high, last_idx=20 → grants alternate 5, 20, 5; last_idx=5 with only req[5] high → re-grants 5.
4. out_ready=0 for 10 cycles in HOLD, mux_out toggled meanwhile → out_data stays at its captured value and out_valid stays 1; no new sel change; accepted on the first out_ready=1 cycle.
5. SETTLE_CYCLES=4, req[12] high → sel=12 for 4 cycles; mux_out is sampled only on the last of them (earlier mux_out values are ignored).
6. rst asserted during SETTLE, and separately enable=0 with pending req → reset values next cycle with no gnt; enable=0 keeps busy=0 and sel unchanged, while an in-flight transaction still completes.
